n_register_chain: RTL and testbench

//   Fixed-latency delay line: an N-deep chain of W-bit registers.

---
 rtl/n_register_chain_pkg.sv | 4 +
 rtl/n_register_chain_if.sv | 12 +
 rtl/n_register_chain_stage.sv | 16 +
 rtl/n_register_chain.sv | 49 ++++
 tb/tb_n_register_chain.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/n_register_chain_pkg.sv
// Shared datapath constants for the matrix-multiply delay-line blocks.
package n_register_chain_pkg;
    localparam int DATA_W = 16;
endpackage

// File: rtl/n_register_chain_if.sv
// Data bundle for one delay-line lane: word in, delayed word out.
interface n_register_chain_if
    import n_register_chain_pkg::*;
#(
    parameter int W = DATA_W
);
    logic [W-1:0] in;
    logic [W-1:0] out;

    modport master (output in, input out);
    modport slave  (input in, output out);
endinterface

// File: rtl/n_register_chain_stage.sv
// One W-bit pipeline register with asynchronous active-low clear.
module n_register_chain_stage
    import n_register_chain_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) q <= '0;
        else          q <= d;
    end
endmodule

// File: rtl/n_register_chain.sv
// N-deep, W-bit fixed-latency delay line; N=0 is a combinational bypass.
// Optional stage taps under macro N_REGISTER_CHAIN_TAPS_EN.
module n_register_chain
    import n_register_chain_pkg::*;
#(
    parameter int N = 3,
    parameter int W = DATA_W,
    localparam int TAPS_W = (N > 0) ? N * W : 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [W-1:0]      in,
`ifdef N_REGISTER_CHAIN_TAPS_EN
    output logic [TAPS_W-1:0] taps,
`endif
    output logic [W-1:0]      out
);
    if (W < 1 || N < 0 || N > 256) begin : g_bad_params
        $error("n_register_chain: illegal parameters N=%0d W=%0d", N, W);
    end

    if (N == 0) begin : g_bypass
        // Clock and reset intentionally have no effect in the bypass build.
        logic unused_ctrl;
        assign unused_ctrl = Clock ^ Reset_n;
        assign out = in;
`ifdef N_REGISTER_CHAIN_TAPS_EN
        assign taps = '0;
`endif
    end else begin : g_chain
        // chain[k] feeds stage k; chain[k+1] is its output.
        logic [W-1:0] chain [N+1];
        assign chain[0] = in;

        for (genvar k = 0; k < N; k++) begin : g_stage
            n_register_chain_stage #(.W(W)) u_stage (
                .Clock   (Clock),
                .Reset_n (Reset_n),
                .d       (chain[k]),
                .q       (chain[k+1])
            );
`ifdef N_REGISTER_CHAIN_TAPS_EN
            assign taps[k*W +: W] = chain[k+1];
`endif
        end

        assign out = chain[N];
    end
endmodule

// File: tb/tb_n_register_chain.sv
// Directed bench for n_register_chain: N=3/W=16 main lane plus N/W sweep lanes.
module tb_n_register_chain;
    import n_register_chain_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    n_register_chain_if #(.W(DATA_W)) bus ();

`ifdef N_REGISTER_CHAIN_TAPS_EN
    logic [47:0] taps;
`endif

    n_register_chain #(.N(3), .W(16)) u_dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .in      (bus.in),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps    (taps),
`endif
        .out     (bus.out)
    );

    logic [0:0]  o0_1, o1_1, o8_1;
    logic [31:0] o0_32, o1_32, o8_32;
    logic [0:0]  x_bit;
    assign x_bit = x[0];

    n_register_chain #(.N(0), .W(1)) u_n0_w1 (.Clock(clk), .Reset_n(rst_n), .in(x_bit),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps(),
`endif
        .out(o0_1));
    n_register_chain #(.N(1), .W(1)) u_n1_w1 (.Clock(clk), .Reset_n(rst_n), .in(x_bit),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps(),
`endif
        .out(o1_1));
    n_register_chain #(.N(8), .W(1)) u_n8_w1 (.Clock(clk), .Reset_n(rst_n), .in(x_bit),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps(),
`endif
        .out(o8_1));
    n_register_chain #(.N(0), .W(32)) u_n0_w32 (.Clock(clk), .Reset_n(rst_n), .in(x),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps(),
`endif
        .out(o0_32));
    n_register_chain #(.N(1), .W(32)) u_n1_w32 (.Clock(clk), .Reset_n(rst_n), .in(x),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps(),
`endif
        .out(o1_32));
    n_register_chain #(.N(8), .W(32)) u_n8_w32 (.Clock(clk), .Reset_n(rst_n), .in(x),
`ifdef N_REGISTER_CHAIN_TAPS_EN
        .taps(),
`endif
        .out(o8_32));

    // Model: every word captured since reset, oldest first; a lane of depth n
    // shows the word captured n edges ago, or 0 if fewer than n edges happened.
    logic [31:0] hist_main [$];
    logic [31:0] hist_x    [$];

    function automatic logic [31:0] past(input logic [31:0] h [$], input int n,
                                         input logic [31:0] now);
        if (n == 0)         return now;
        if (h.size() < n)   return '0;
        return h[h.size() - n];
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            hist_main.push_back({16'h0, bus.in});
            hist_x.push_back(x);
        end
    end

    always @(negedge rst_n) begin
        hist_main.delete();
        hist_x.delete();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        check("model_main", {48'h0, bus.out}, {32'h0, past(hist_main, 3, '0)});
        check("sweep_n0_w1",  {63'h0, o0_1},  {63'h0, past(hist_x, 0, x) & 32'h1});
        check("sweep_n1_w1",  {63'h0, o1_1},  {63'h0, past(hist_x, 1, x) & 32'h1});
        check("sweep_n8_w1",  {63'h0, o8_1},  {63'h0, past(hist_x, 8, x) & 32'h1});
        check("sweep_n0_w32", {32'h0, o0_32}, {32'h0, past(hist_x, 0, x)});
        check("sweep_n1_w32", {32'h0, o1_32}, {32'h0, past(hist_x, 1, x)});
        check("sweep_n8_w32", {32'h0, o8_32}, {32'h0, past(hist_x, 8, x)});
    end

    // Present a word, let the next rising edge capture it, settle 2 ns after.
    task automatic step(input logic [15:0] v);
        bus.in = v;
        x = $urandom;
        @(posedge clk);
        #2;
    endtask

    logic [15:0] seq_in  [12] = '{16'h1111, 16'h2222, 16'h4A55, 16'h515F,
                                  16'h0001, 16'h0001, 16'h0001, 16'h0001,
                                  16'hCCCC, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] seq_out [12] = '{16'h0000, 16'h0000, 16'h1111, 16'h2222,
                                  16'h4A55, 16'h515F, 16'h0001, 16'h0001,
                                  16'h0001, 16'h0001, 16'hCCCC, 16'h0000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        bus.in = 16'hFFFF;
        x      = 32'hFFFF_FFFF;
        #3;
        check("reset_out", {48'h0, bus.out}, 64'h0);
        @(posedge clk); #2;
        check("reset_hold_out", {48'h0, bus.out}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(seq_in[i]);
            check($sformatf("seq_out[%0d]", i), {48'h0, bus.out}, {48'h0, seq_out[i]});
        end

        // Three words in flight, then asynchronous reset between edges.
        step(16'hAAAA);
        step(16'hBBBB);
        step(16'hDDDD);
        check("inflight_out", {48'h0, bus.out}, 64'h0000_0000_0000_AAAA);
        #1 rst_n = 1'b0;
        #1;
        check("async_clear", {48'h0, bus.out}, 64'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(16'h0000);
            check($sformatf("no_replay[%0d]", i), {48'h0, bus.out}, 64'h0);
        end

`ifdef N_REGISTER_CHAIN_TAPS_EN
        #1 rst_n = 1'b0;
        #1;
        check("taps_reset", {16'h0, taps}, 64'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step(16'h000A);
        step(16'h000B);
        step(16'h000C);
        check("taps_stream", {16'h0, taps}, 64'h0000_000A_000B_000C);
        check("taps_out", {48'h0, bus.out}, 64'h0000_0000_0000_000A);
`endif

        for (int i = 0; i < 40; i++) step(16'($urandom));

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
